// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction/data) to single memory arbiter with data priority and ack timeout
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_rd_i,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_data_o,
  output logic        instr_ready_o,
  input  logic        data_rd_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_o
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;
  state_t        state_q, state_d;
  logic          req_q, req_d, we_q, we_d, err_q, err_d;
  logic          i_srv_q, i_srv_d, d_srv_q, d_srv_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, idata_q, idata_d, drdata_q, drdata_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          d_req, adv, to, done;
  logic [31:0]   rd;
  assign d_req         = data_rd_i | data_wr_i;
  assign instr_ready_o = ~instr_rd_i | i_srv_q;
  assign data_ready_o  = ~d_req | d_srv_q;
  assign adv           = instr_ready_o & data_ready_o;
  // Timeout fires on the edge where the wait counter would reach TIMEOUT; a real ack wins.
  assign to            = (TIMEOUT != 0) && (state_q != IDLE) && !mem_ack_i && (wait_q == CW'(TIMEOUT - 1));
  assign done          = (state_q != IDLE) && (mem_ack_i || to);
  assign rd            = to ? ERR_DATA : mem_rdata_i;
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign instr_data_o  = idata_q;
  assign data_rdata_o  = drdata_q;
  assign err_o         = err_q;
  // Next-state: start accesses from IDLE (data first), complete them on ack or timeout.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idata_d  = idata_q;
    drdata_d = drdata_q;
    wait_d   = wait_q;
    err_d    = err_q | to;
    i_srv_d  = adv ? 1'b0 : i_srv_q;
    d_srv_d  = adv ? 1'b0 : d_srv_q;
    case (state_q)
      IDLE: begin
        if (d_req && !d_srv_q && !adv) begin
          state_d = D_ACC;
          req_d   = 1'b1;
          we_d    = data_wr_i;
          addr_d  = data_addr_i;
          wdata_d = data_wdata_i;
          wait_d  = '0;
        end else if (instr_rd_i && !i_srv_q && !adv) begin
          state_d = I_ACC;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = instr_addr_i;
          wdata_d = '0;
          wait_d  = '0;
        end
      end
      D_ACC, I_ACC: begin
        if (done) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (state_q == D_ACC) begin
            drdata_d = we_q ? drdata_q : rd;
            d_srv_d  = d_req ? 1'b1 : d_srv_d;
          end else begin
            idata_d = rd;
            i_srv_d = instr_rd_i ? 1'b1 : i_srv_d;
          end
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idata_q  <= '0;
      drdata_q <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
      i_srv_q  <= 1'b0;
      d_srv_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      idata_q  <= idata_d;
      drdata_q <= drdata_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      i_srv_q  <= i_srv_d;
      d_srv_q  <= d_srv_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table-driven and sequence checks for mem_arbiter
module tb_mem_arbiter;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        instr_rd_i = 1'b0, data_rd_i = 1'b0, data_wr_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] instr_addr_i = '0, data_addr_i = '0, data_wdata_i = '0, mem_rdata_i = '0;
  logic [31:0] instr_data_o, data_rdata_o, mem_addr_o, mem_wdata_o;
  logic        instr_ready_o, data_ready_o, mem_req_o, mem_we_o, err_o;
  int checks = 0, failures = 0;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  always #5 clk_i = ~clk_i;
  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_rd_i(instr_rd_i), .instr_addr_i(instr_addr_i), .instr_data_o(instr_data_o), .instr_ready_o(instr_ready_o),
    .data_rd_i(data_rd_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o), .data_ready_o(data_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .err_o(err_o)
  );
  typedef struct {logic ir, dr, dw, e_ir, e_dr;} cvec_t;
  typedef struct {logic d, rd, wr; logic [31:0] addr, wdata, rdata, e_i, e_d;} avec_t;
  cvec_t cv[8];
  avec_t av[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask
  // Zero-wait single-port access: request in cycle N, req in N+1, ready in N+2.
  task automatic acc(input avec_t v);
    if (v.d) begin
      data_rd_i = v.rd; data_wr_i = v.wr; data_addr_i = v.addr; data_wdata_i = v.wdata;
    end else begin
      instr_rd_i = 1'b1; instr_addr_i = v.addr;
    end
    #1;
    chk("acc_ready_low", {31'b0, v.d ? data_ready_o : instr_ready_o}, 32'd0);
    tick();
    chk("acc_req", {31'b0, mem_req_o}, 32'd1);
    chk("acc_addr", mem_addr_o, v.addr);
    chk("acc_we", {31'b0, mem_we_o}, {31'b0, v.d & v.wr});
    if (v.d && v.wr) chk("acc_wdata", mem_wdata_o, v.wdata);
    mem_ack_i = 1'b1; mem_rdata_i = v.rdata;
    tick();
    mem_ack_i = 1'b0;
    chk("acc_req_one_cycle", {31'b0, mem_req_o}, 32'd0);
    chk("acc_ready_n2", {31'b0, v.d ? data_ready_o : instr_ready_o}, 32'd1);
    chk("acc_instr_data", instr_data_o, v.e_i);
    chk("acc_data_rdata", data_rdata_o, v.e_d);
    tick();
    instr_rd_i = 1'b0; data_rd_i = 1'b0; data_wr_i = 1'b0;
  endtask
  // Memory responder: wait (bounded) for req, hold `delay` cycles, then ack once.
  task automatic serve(input int delay, input logic [31:0] rdata, input logic [31:0] exp_addr);
    int n = 0;
    while (!mem_req_o && n < 10) begin
      tick();
      n++;
    end
    chk("serve_req_seen", {31'b0, mem_req_o}, 32'd1);
    chk("serve_addr", mem_addr_o, exp_addr);
    repeat (delay) begin
      tick();
      chk("serve_hold", {mem_addr_o[30:0], mem_req_o}, {exp_addr[30:0], 1'b1});
    end
    mem_ack_i = 1'b1; mem_rdata_i = rdata;
    tick();
    mem_ack_i = 1'b0;
    chk("serve_req_clr", {31'b0, mem_req_o}, 32'd0);
  endtask
  initial begin
    logic [31:0] ba[3];
    int cnt;
    cv[0] = '{0,0,0,1,1}; cv[1] = '{1,0,0,0,1}; cv[2] = '{0,1,0,1,0}; cv[3] = '{0,0,1,1,0};
    cv[4] = '{1,1,0,0,0}; cv[5] = '{1,0,1,0,0}; cv[6] = '{0,1,1,1,0}; cv[7] = '{1,1,1,0,0};
    av[0] = '{0,0,0,32'h10, 32'h0, 32'h00500093, 32'h00500093, 32'h0};
    av[1] = '{1,1,0,32'h100,32'h0, 32'h11112222, 32'h00500093, 32'h11112222};
    av[2] = '{1,1,1,32'h200,32'hCAFEF00D,32'h55555555,32'h00500093,32'h11112222};
    av[3] = '{1,0,1,32'h204,32'h12345678,32'h66666666,32'h00500093,32'h11112222};
    av[4] = '{0,0,0,32'h14, 32'h0, 32'h00A00113, 32'h00A00113, 32'h11112222};
    ba[0] = 32'h40; ba[1] = 32'h44; ba[2] = 32'h48;
    #2;
    chk("rst_outputs", {mem_req_o, mem_we_o, err_o, mem_addr_o[28:0]}, 32'd0);
    chk("rst_rdata", instr_data_o | data_rdata_o | mem_wdata_o, 32'd0);
    for (int i = 0; i < 8; i++) begin
      instr_rd_i = cv[i].ir; data_rd_i = cv[i].dr; data_wr_i = cv[i].dw;
      #1;
      chk($sformatf("ready_comb%0d", i), {30'b0, instr_ready_o, data_ready_o}, {30'b0, cv[i].e_ir, cv[i].e_dr});
    end
    instr_rd_i = 1'b0; data_rd_i = 1'b0; data_wr_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    chk("idle_ready", {30'b0, instr_ready_o, data_ready_o}, 32'd3);
    for (int i = 0; i < 5; i++) acc(av[i]);
    tick();
    // Simultaneous requests: data first, then instruction; both ready together.
    data_rd_i = 1'b1; data_addr_i = 32'h100; instr_rd_i = 1'b1; instr_addr_i = 32'h14;
    serve(3, 32'hA5A5A5A5, 32'h100);
    chk("both_d_ready", {30'b0, instr_ready_o, data_ready_o}, 32'd1);
    chk("both_d_data", data_rdata_o, 32'hA5A5A5A5);
    serve(3, 32'h00C00193, 32'h14);
    chk("both_ready", {30'b0, instr_ready_o, data_ready_o}, 32'd3);
    chk("both_i_data", instr_data_o, 32'h00C00193);
    chk("both_no_err", {31'b0, err_o}, 32'd0);
    tick();
    chk("srv_cleared", {30'b0, instr_ready_o, data_ready_o}, 32'd0);
    instr_rd_i = 1'b0; data_rd_i = 1'b0;
    tick();
    chk("quiet_after_drop", {31'b0, mem_req_o}, 32'd0);
    // Back-to-back instruction fetches, new address after each advance.
    instr_rd_i = 1'b1; instr_addr_i = ba[0];
    for (int k = 0; k < 3; k++) begin
      serve(0, 32'h1000 + k, ba[k]);
      chk("b2b_ready", {31'b0, instr_ready_o}, 32'd1);
      chk("b2b_data", instr_data_o, 32'h1000 + k);
      tick();
      chk("b2b_no_dup", {31'b0, mem_req_o}, 32'd0);
      if (k < 2) instr_addr_i = ba[k + 1];
      else instr_rd_i = 1'b0;
    end
    repeat (3) begin
      tick();
      chk("b2b_quiet", {31'b0, mem_req_o}, 32'd0);
    end
    // Timeout on an instruction read with no ack.
    instr_rd_i = 1'b1; instr_addr_i = 32'h30;
    tick();
    cnt = 0;
    while (mem_req_o && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("to_cycles", cnt, 32'd4);
    chk("to_data", instr_data_o, ERR);
    chk("to_err", {31'b0, err_o}, 32'd1);
    chk("to_ready", {31'b0, instr_ready_o}, 32'd1);
    tick();
    instr_rd_i = 1'b0;
    repeat (3) tick();
    chk("err_sticky", {31'b0, err_o}, 32'd1);
    // Reset in the middle of a data access; later ack must be ignored.
    data_rd_i = 1'b1; data_addr_i = 32'h300;
    tick();
    chk("mid_req", {31'b0, mem_req_o}, 32'd1);
    tick();
    rst_i = 1'b0; data_rd_i = 1'b0;
    #1;
    chk("mid_rst_req", {30'b0, mem_req_o, err_o}, 32'd0);
    chk("mid_rst_addr", mem_addr_o, 32'd0);
    chk("mid_rst_data", instr_data_o | data_rdata_o, 32'd0);
    tick();
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777;
    tick();
    mem_ack_i = 1'b0;
    chk("post_rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("post_rst_rdata", data_rdata_o, 32'd0);
    chk("post_rst_ready", {30'b0, instr_ready_o, data_ready_o}, 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock, clk_i; reset rst_i SHALL be asynchronous and active-low.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum wait cycles for mem_ack_i; 0 SHALL disable the timeout.
REQ-003 Parameter ERR_DATA, default 32'hDEADBEEF, SHALL be the read data returned on a timed-out access.
REQ-004 Ports SHALL be as follows:
- clk_i  in  1  clock
- rst_i  in  1  async active-low reset
- instr_rd_i  in  1  CPU instruction read request
- instr_addr_i  in  32  instruction address
- instr_data_o  out  32  instruction read data
- instr_ready_o  out  1  instruction port ready
- data_rd_i  in  1  CPU data read request
- data_wr_i  in  1  CPU data write request
- data_addr_i  in  32  data address
- data_wdata_i  in  32  data write data
- data_rdata_o  out  32  data read data
- data_ready_o  out  1  data port ready
- mem_req_o  out  1  shared memory request
- mem_we_o  out  1  shared memory write enable
- mem_addr_o  out  32  shared memory address
- mem_wdata_o  out  32  shared memory write data
- mem_rdata_i  in  32  shared memory read data, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle access-complete pulse
- err_o  out  1  sticky timeout flag

Function
REQ-005 The FSM SHALL have three states: IDLE, D_ACC (data access) and I_ACC (instruction access).
REQ-006 Per-port served flags i_srv and d_srv SHALL record completion of the current request.
REQ-007 instr_ready_o SHALL equal ~instr_rd_i | i_srv, combinationally.
REQ-008 data_ready_o SHALL equal ~(data_rd_i | data_wr_i) | d_srv, combinationally.
REQ-009 An advance cycle is one where instr_ready_o and data_ready_o are both 1; at its clock edge, i_srv and d_srv SHALL clear to 0.
REQ-010 IDLE transitions SHALL be:
- data request and !d_srv and not an advance cycle -> D_ACC
- else instr_rd_i and !i_srv and not an advance cycle -> I_ACC
- else stay in IDLE
REQ-011 Data SHALL have fixed priority over instruction.
REQ-012 On entering D_ACC/I_ACC, the block SHALL register mem_addr_o and mem_wdata_o from the selected port and set mem_req_o=1.
REQ-013 mem_we_o SHALL be 1 only for a data write.
REQ-014 When data_rd_i and data_wr_i are both 1, the access SHALL be a write.
REQ-015 mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL hold stable until mem_ack_i or timeout.
REQ-016 On mem_ack_i in D_ACC/I_ACC:
- mem_req_o and mem_we_o SHALL clear
- for a read, mem_rdata_i SHALL be latched into data_rdata_o or instr_data_o
- the served flag SHALL be set
- the FSM SHALL return to IDLE
REQ-017 A read result SHALL hold on its output until the next read on the same port completes.
REQ-018 mem_ack_i SHALL be ignored in IDLE.
REQ-019 With zero-wait memory (ack in the first mem_req_o cycle), a request presented in cycle N SHALL see ready=1 in cycle N+2.
REQ-020 A wait counter SHALL reset to 0 on entry to D_ACC/I_ACC and increment each access cycle without ack.
REQ-021 When TIMEOUT!=0 and the wait counter reaches TIMEOUT:
- the access SHALL complete as if acked, with read data ERR_DATA
- err_o SHALL set
REQ-022 err_o SHALL clear only on reset.
REQ-023 Requests SHALL be stable while the corresponding ready is 0; a request that drops before service SHALL leave its served flag clear.
REQ-024 When both ports are served in the same window, the memory side SHALL perform the data access then the instruction access, back-to-back through IDLE.

Reset
REQ-025 rst_i=0 SHALL immediately force:
- state IDLE
- mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, instr_data_o, data_rdata_o = 0
- i_srv, d_srv, wait counter, err_o = 0
REQ-026 Reset asserted mid-access SHALL abort that access with no result latched; a subsequent mem_ack_i SHALL be ignored.
REQ-027 After reset with no requests, instr_ready_o=1 and data_ready_o=1.

Verification
REQ-028 Instruction read only, addr 0x10, zero-wait ack with rdata 0x00500093 -> mem_req_o high 1 cycle; instr_ready_o=1 two cycles after request; instr_data_o=0x00500093.
REQ-029 Simultaneous data read 0x100 and instruction read 0x14, ack delayed 3 cycles each -> data access first, then instruction; both readies=1 in the same cycle; served flags clear next edge.
REQ-030 data_rd_i=1 and data_wr_i=1 together, addr 0x200, wdata 0xCAFEF00D -> mem_we_o=1, mem_wdata_o=0xCAFEF00D; data_rdata_o unchanged.
REQ-031 TIMEOUT=4, no ack on instruction read -> completion after 4 wait cycles; instr_data_o=0xDEADBEEF; err_o=1 and held until reset.
REQ-032 rst_i low during D_ACC wait, ack pulsed after release -> outputs 0 immediately; ack ignored; FSM in IDLE.
REQ-033 Back-to-back advance cycles with new addresses each time -> no duplicated or skipped memory access; each access uses the address present after the advance.
